gf2m_digit_serial_mult: RTL and testbench
=========================================

Name: gf2m_digit_serial_mult

Overview:
- Sequential GF(2^M) multiplier: computes c = a·b mod f(x), where f(x) = x^M + POLY(x) and all arithmetic is carry-less over GF(2).
- Successor to the team's combinational Karatsuba carry-less multiplier. It adds modular reduction, configurable digit-serial throughput and a valid/ready handshake.
- Sits in the finite-field arithmetic datapath (ECC / AES-style field ops) wherever the area of a full combinational M×M product is not acceptable.

Parameters:
- M, 8, field degree; operand and result width in bits; M ≥ 2.
- D, 2, digit size: bits of b consumed per BUSY cycle; 1 ≤ D ≤ M.
- POLY, 8'h1B, low M bits of f(x); x^M term is implicit; POLY[0] must be 1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a, b presented.
- in_ready  out  1  block can accept operands.
- a  in  M  multiplicand, field element (polynomial basis, bit i = coefficient of x^i).
- b  in  M  multiplier, field element.
- out_valid  out  1  result on c is valid.
- out_ready  in  1  downstream accepts c.
- c  out  M  product a·b mod f.
- busy  out  1  high while in BUSY state.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Constant N = ceil(M/D) = number of digits.
- Reset: state←IDLE, in_ready=1, out_valid=0, busy=0, c=0, counter=0, accumulator=0.
  - Reset overrides any in-flight operation; the partial result is discarded.
  - An out_valid pending during reset is dropped.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge t: latch a into A_r; zero-extend b to N·D bits into B_r (padding at MSB end); acc←0; cnt←0; state←BUSY.
  - BUSY: in_ready=0, busy=1. Each edge processes digit d = B_r[(N-1-cnt)·D +: D], MSB digit first:
    - acc ← (acc·x^D mod f) XOR (A_r·d mod f).
    - cnt←cnt+1.
    - When cnt==N-1, c←new acc, out_valid←1, state←DONE.
  - DONE: in_ready=0, busy=0, c held stable, out_valid=1. On out_ready: out_valid←0, state←IDLE.
- Latency: accept at edge t gives out_valid=1 after edge t+N. Minimum initiation interval is N+2 cycles.
- No same-cycle accept in DONE: in_ready stays low until IDLE is re-entered. in_valid while not ready is ignored; a and b are not sampled.
- out_ready while out_valid=0 has no effect. Backpressure holds DONE indefinitely with c unchanged.
- Reduction, per cycle, combinational, D ≤ M:
  - The D-step shift of acc is D repeated steps of v←(v<<1) with XOR of POLY when the bit shifted out of position M-1 is 1.
  - A_r·d is the XOR of (A_r·x^j mod f) for each set bit j of d, using the same step-wise reduction.
  - All intermediate results are M bits.
- Leading zero digits from padding (M mod D ≠ 0) produce acc=0 contributions and need no special case.
- a=0 or b=0 gives c=0. b=1 gives c=a.

Test Plan:
- M=8, D=2, POLY=8'h1B: a=8'h57, b=8'h83 → out_valid after exactly 4 cycles, c=8'hC1. Second op a=8'h57, b=8'h13 → c=8'hFE.
- Digit-size sweep with same operands 8'h02·8'h87:
  - D=1 (N=8), D=3 (N=3, padded), D=8 (N=1).
  - Required: c=8'h15 in every case, latency 8/3/1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after completion.
  - c and out_valid stay stable.
  - in_ready=0 throughout; an in_valid pulse during this window is not accepted.
  - Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-op: assert rst in the 2nd BUSY cycle.
  - Next cycle: in_ready=1, out_valid=0, busy=0, c=0.
  - A fresh op a=8'hFF, b=8'h01 then yields c=8'hFF.
- Edge operands: a=0, b=8'hA5 → c=0. a=8'h53, b=8'hCA (inverse pair) → c=8'h01.
- Random: 1000 ops, M=8, D=1..8, random out_ready stalls. Every c matches the reference model; the accepted count equals the delivered count.

Source files
------------

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier: c = a*b mod (x^M + POLY).
// Consumes D bits of b per cycle, MSB digit first, with a valid/ready handshake.
module gf2m_digit_serial_mult #(
  parameter int          M    = 8,
  parameter int          D    = 2,
  parameter logic [M-1:0] POLY = M'(8'h1B)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c,
  output logic         busy
);

  localparam int N  = (M + D - 1) / D;
  localparam int NW = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  logic [M-1:0]   a_r;
  logic [NW-1:0]  b_r;
  logic [M-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [D-1:0]   dig;
  logic [M-1:0]   nxt;

  // One multiply-by-x step with reduction by f(x).
  function automatic logic [M-1:0] xt(
    input logic [M-1:0] v
  );
    xt = {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // b_r shifts left each digit, so the active digit is always on top.
  assign dig = b_r[NW-1 -: D];

  always_comb begin
    logic [M-1:0] sh;
    logic [M-1:0] ap;
    logic [M-1:0] prod;
    sh   = acc;
    ap   = a_r;
    prod = '0;
    for (int i = 0; i < D; i++) begin
      sh = xt(sh);
      if (dig[i]) prod = prod ^ ap;
      ap = xt(ap);
    end
    nxt = sh ^ prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      c         <= '0;
      cnt       <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= NW'(b);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= nxt;
          b_r <= b_r << D;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            c         <= nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Scoreboard bench for gf2m_digit_serial_mult.
// Directed D=2 instance plus one randomised instance per digit size 1..8.
module tb_gf2m_digit_serial_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ndone  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] c;
    int         lat;
    int         tacc;
  } exp_t;

  function automatic logic [7:0] gfmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic       rst0, iv0, ir0, ov0, or0, busy0;
  logic [7:0] a0, b0, c0;
  logic       hold = 1'b0;
  logic       rstg;
  assign or0 = !hold;

  gf2m_digit_serial_mult #(.M(8), .D(2), .POLY(8'h1B)) u0 (
    .clk(clk), .rst(rst0),
    .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0),
    .c(c0), .busy(busy0)
  );

  exp_t q0[$];
  bit   seen0 = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst0 || !ov0) seen0 = 0;
      else if (!seen0) begin
        seen0 = 1;
        if (q0.size() == 0) chk("u0 unexpected result", 1, 0);
        else begin
          e = q0.pop_front();
          chk("u0 c", c0, e.c);
          chk("u0 latency", cyc - e.tacc, e.lat);
        end
      end
    end
  end

  task automatic send0(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ex, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    a0 = x; b0 = y; iv0 = 1'b1;
    while (!ir0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir0) chk("u0 accept timeout", 0, 1);
    else if (push) q0.push_back('{ex, 4, cyc + 1});
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic wait_idle0;
    int n;
    n = 0;
    while (!ir0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir0) chk("u0 idle timeout", 0, 1);
  endtask

  for (genvar k = 1; k <= 8; k++) begin : g
    localparam int NN = (8 + k - 1) / k;
    logic       iv, ir, ov, orr, bz;
    logic [7:0] a, b, c;
    exp_t       q[$];
    int         acc_n = 0;
    int         del_n = 0;
    bit         seen  = 0;
    logic [7:0] held;

    gf2m_digit_serial_mult #(.M(8), .D(k), .POLY(8'h1B)) u (
      .clk(clk), .rst(rstg),
      .in_valid(iv), .in_ready(ir),
      .a(a), .b(b),
      .out_valid(ov), .out_ready(orr),
      .c(c), .busy(bz)
    );

    initial begin
      int n;
      logic [7:0] ra, rb, ex;
      iv = 1'b0; a = '0; b = '0;
      @(negedge clk);
      while (rstg) @(negedge clk);
      for (int i = 0; i < 125; i++) begin
        if (i == 0) begin
          ra = 8'h02; rb = 8'h87; ex = 8'h15;
        end else begin
          ra = 8'($urandom); rb = 8'($urandom); ex = gfmul(ra, rb);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a = ra; b = rb; iv = 1'b1; n = 0;
        while (!ir && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (!ir) begin
          chk($sformatf("g%0d accept timeout", k), 0, 1);
          iv = 1'b0;
          break;
        end
        q.push_back('{ex, NN, cyc + 1});
        acc_n++;
        @(negedge clk);
        iv = 1'b0;
      end
      n = 0;
      while (del_n != acc_n && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("g%0d delivered count", k), del_n, acc_n);
      ndone++;
    end

    initial begin
      exp_t e;
      orr = 1'b0;
      forever begin
        @(negedge clk);
        if (!ov) seen = 0;
        else if (!seen) begin
          seen = 1;
          held = c;
          del_n++;
          if (q.size() == 0) chk($sformatf("g%0d unexpected result", k), 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("g%0d c", k), c, e.c);
            chk($sformatf("g%0d latency", k), cyc - e.tacc, e.lat);
          end
        end else chk($sformatf("g%0d stall c stable", k), c, held);
        orr = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    int n;
    rst0 = 1'b1; rstg = 1'b1;
    iv0 = 1'b0; a0 = '0; b0 = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", ir0, 1);
    chk("reset out_valid", ov0, 0);
    chk("reset busy", busy0, 0);
    chk("reset c", c0, 0);
    rst0 = 1'b0; rstg = 1'b0;

    send0(8'h57, 8'h83, 8'hC1, 1); wait_idle0();
    send0(8'h57, 8'h13, 8'hFE, 1); wait_idle0();
    send0(8'h00, 8'hA5, 8'h00, 1); wait_idle0();
    send0(8'h53, 8'hCA, 8'h01, 1); wait_idle0();

    hold = 1'b1;
    send0(8'h57, 8'h83, 8'hC1, 1);
    n = 0;
    while (!ov0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp out_valid rise", ov0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        a0 = 8'hFF; b0 = 8'hFF; iv0 = 1'b1;
      end
      if (i == 5) iv0 = 1'b0;
      chk("bp out_valid held", ov0, 1);
      chk("bp c held", c0, 8'hC1);
      chk("bp in_ready low", ir0, 0);
      @(negedge clk);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("bp in_ready after release", ir0, 1);
    chk("bp out_valid after release", ov0, 0);
    repeat (3) @(negedge clk);
    chk("bp pulse not accepted", busy0, 0);

    send0(8'h57, 8'h83, 8'hC1, 0);
    chk("mid busy", busy0, 1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("mid rst in_ready", ir0, 1);
    chk("mid rst out_valid", ov0, 0);
    chk("mid rst busy", busy0, 0);
    chk("mid rst c", c0, 0);
    send0(8'hFF, 8'h01, 8'hFF, 1); wait_idle0();
    repeat (2) @(negedge clk);
    chk("u0 queue drained", q0.size(), 0);

    n = 0;
    while (ndone < 8 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("random instances finished", ndone, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
